ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_pkg.sv | 36 +++
 rtl/ifq_fifo.sv | 67 ++++++
 rtl/ifetch_queue.sv | 112 +++++++++++
 tb/tb_ifetch_queue.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: bus structs, queue entry,
// fetch FSM states and the PC-advance helper.
package ifetch_queue_pkg;

  localparam int IFQ_DEPTH_DEFAULT = 4;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  // Sequential PC advance; wraps modulo 2^64, no alignment check.
  function automatic u64 next_pc(input u64 pc, input int step);
    return pc + 64'(step);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries. Flush beats push and pop;
// the head entry is presented combinationally from the read pointer.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (cnt != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(do_push && !do_pop && cnt == FULL));
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: single-outstanding request FSM on the
// instruction bus feeding a DEPTH-entry queue toward decode, with redirects.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH_DEFAULT,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output ibus_req_t              ireq,
  input  ibus_resp_t             iresp,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   out_valid,
  output logic [63:0]            out_pc,
  output logic [31:0]            out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state, state_next;
  logic [63:0]      fetch_pc, fetch_pc_next;
  logic [63:0]      req_addr, req_addr_next;
  logic             req_valid, req_valid_next;
  logic             push;
  fetch_entry_t     push_data;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      req_valid <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      req_addr  <= req_addr_next;
      req_valid <= req_valid_next;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    req_addr_next  = req_addr;
    req_valid_next = req_valid;
    push           = 1'b0;

    unique case (state)
      IDLE: begin
        // Occupancy is taken as-is; a pop this cycle is not credited.
        if (!redirect_valid && fifo_count < CNT_W'(DEPTH)) begin
          req_addr_next  = fetch_pc;
          req_valid_next = 1'b1;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (iresp.data_ok) begin
          req_valid_next = 1'b0;
          state_next     = IDLE;
          if (!redirect_valid) begin
            push          = 1'b1;
            fetch_pc_next = next_pc(req_addr, PC_STEP);
          end
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (iresp.data_ok) begin
          req_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A redirect always wins for the next fetch address.
    if (redirect_valid) fetch_pc_next = redirect_pc;
  end

  assign push_data = '{pc: req_addr, instr: iresp.data};
  assign ireq      = '{valid: req_valid, addr: req_addr};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (out_valid && out_ready),
    .head       (head),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign count     = fifo_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a DEPTH=4 instance driven cycle by cycle,
// and a DEPTH=2 instance with an automatic bus responder for pointer wrap.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  logic        reset2;
  ibus_req_t   ireq2;
  ibus_resp_t  iresp2;
  logic        out_valid2;
  logic [63:0] out_pc2;
  logic [31:0] out_instr2;
  logic        out_ready2;
  logic [1:0]  count2;
  logic        auto2;

  int tests_run    = 0;
  int tests_failed = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(RPC), .PC_STEP(4)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready),
    .count          (count)
  );

  ifetch_queue #(.DEPTH(2), .RESET_PC(RPC), .PC_STEP(4)) u_dut2 (
    .clk            (clk),
    .reset          (reset2),
    .ireq           (ireq2),
    .iresp          (iresp2),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .out_valid      (out_valid2),
    .out_pc         (out_pc2),
    .out_instr      (out_instr2),
    .out_ready      (out_ready2),
    .count          (count2)
  );

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Second instance: data_ok in the first cycle its request is visible.
  always @(negedge clk) begin
    if (auto2) begin
      iresp2.data_ok = ireq2.valid && !iresp2.data_ok;
      iresp2.data    = instr_of(ireq2.addr);
    end else begin
      iresp2.data_ok = 1'b0;
      iresp2.data    = 32'h0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(output logic [63:0] a, output bit got);
    got = 1'b0;
    a   = '0;
    for (int i = 0; i < 32; i++) begin
      if (ireq.valid) begin
        got = 1'b1;
        a   = ireq.addr;
        return;
      end
      tick();
    end
  endtask

  // Answer the visible request one cycle after it appeared.
  task automatic serve(input logic [63:0] a);
    tick();
    iresp.data_ok = 1'b1;
    iresp.data    = instr_of(a);
    tick();
    iresp.data_ok = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    iresp.data_ok  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %0b expected 0", ireq.valid); end
    tests_run++;
    if (ireq.addr !== RPC) begin tests_failed++; $display("FAIL reset_req_addr: got %h expected %h", ireq.addr, RPC); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (ireq.valid !== 1'b1 || ireq.addr !== RPC) begin
      tests_failed++; $display("FAIL first_req: got valid=%0b addr=%h expected valid=1 addr=%h", ireq.valid, ireq.addr, RPC);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] a, exp;
    bit got;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = RPC + 64'(4 * k);
      wait_req(a, got);
      tests_run++;
      if (!got || a !== exp) begin tests_failed++; $display("FAIL seq_req_addr: got %h expected %h", a, exp); end
      tick();
      tests_run++;
      if (ireq.valid !== 1'b1 || ireq.addr !== exp) begin tests_failed++; $display("FAIL seq_req_hold: got %h expected %h", ireq.addr, exp); end
      iresp.data_ok = 1'b1;
      iresp.data    = instr_of(exp);
      tick();
      iresp.data_ok = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== instr_of(exp)) begin
        tests_failed++; $display("FAIL seq_out: got v=%0b pc=%h instr=%h expected pc=%h instr=%h", out_valid, out_pc, out_instr, exp, instr_of(exp));
      end
      tests_run++;
      if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL seq_req_drop: got %0b expected 0", ireq.valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    bit got, seen;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_req(a, got);
      tests_run++;
      if (!got || a !== RPC + 64'(4 * k)) begin tests_failed++; $display("FAIL bp_req_addr: got %h expected %h", a, RPC + 64'(4 * k)); end
      serve(a);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ireq.valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL bp_full_no_req: got %0b expected 0", seen); end
    tests_run++;
    if (count !== 3'd4 || out_pc !== RPC) begin tests_failed++; $display("FAIL bp_full: got count=%0d pc=%h expected 4 %h", count, out_pc, RPC); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (count !== 3'd3 || ireq.valid !== 1'b0 || out_pc !== RPC + 64'd4) begin
      tests_failed++; $display("FAIL bp_pop: got count=%0d valid=%0b pc=%h expected 3 0 %h", count, ireq.valid, out_pc, RPC + 64'd4);
    end
    wait_req(a, got);
    tests_run++;
    if (!got || a !== RPC + 64'd16) begin tests_failed++; $display("FAIL bp_refill_addr: got %h expected %h", a, RPC + 64'd16); end
    serve(a);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ireq.valid) seen = 1'b1;
    end
    tests_run++;
    if (count !== 3'd4 || seen !== 1'b0) begin tests_failed++; $display("FAIL bp_one_refill: got count=%0d extra_req=%0b expected 4 0", count, seen); end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] a;
    bit got, held;
    do_reset();
    out_ready = 1'b0;
    wait_req(a, got);
    serve(a);
    wait_req(a, got);
    serve(a);
    wait_req(a, got);
    tests_run++;
    if (!got || a !== RPC + 64'd8) begin tests_failed++; $display("FAIL rw_req_addr: got %h expected %h", a, RPC + 64'd8); end
    redirect_valid = 1'b1;
    redirect_pc    = RPC + 64'h100;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_flush: got count=%0d valid=%0b expected 0 0", count, out_valid); end
    held = ireq.valid && ireq.addr == RPC + 64'd8;
    for (int i = 0; i < 2; i++) begin
      tick();
      held = held && ireq.valid && ireq.addr == RPC + 64'd8;
    end
    tests_run++;
    if (held !== 1'b1) begin tests_failed++; $display("FAIL rw_req_hold: got addr=%h expected %h", ireq.addr, RPC + 64'd8); end
    iresp.data_ok = 1'b1;
    iresp.data    = instr_of(RPC + 64'd8);
    tick();
    iresp.data_ok = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL rw_drop: got valid=%0b count=%0d expected 0 0", out_valid, count); end
    wait_req(a, got);
    tests_run++;
    if (!got || a !== RPC + 64'h100) begin tests_failed++; $display("FAIL rw_target: got %h expected %h", a, RPC + 64'h100); end
    serve(a);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== RPC + 64'h100) begin tests_failed++; $display("FAIL rw_target_out: got pc=%h expected %h", out_pc, RPC + 64'h100); end
  endtask

  task automatic test_redirect_dataok_pop();
    logic [63:0] a;
    bit got;
    wait_req(a, got);
    tests_run++;
    if (!got || a !== RPC + 64'h104) begin tests_failed++; $display("FAIL rdp_req_addr: got %h expected %h", a, RPC + 64'h104); end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rdp_pre_valid: got %0b expected 1", out_valid); end
    iresp.data_ok  = 1'b1;
    iresp.data     = instr_of(a);
    redirect_valid = 1'b1;
    redirect_pc    = RPC + 64'h300;
    out_ready      = 1'b1;
    tick();
    iresp.data_ok  = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || ireq.valid !== 1'b0) begin
      tests_failed++; $display("FAIL rdp_flush: got count=%0d out_valid=%0b req=%0b expected 0 0 0", count, out_valid, ireq.valid);
    end
    wait_req(a, got);
    tests_run++;
    if (!got || a !== RPC + 64'h300) begin tests_failed++; $display("FAIL rdp_target: got %h expected %h", a, RPC + 64'h300); end
  endtask

  task automatic test_double_redirect();
    logic [63:0] a;
    bit got;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (ireq.valid !== 1'b1 || ireq.addr !== RPC + 64'h300) begin tests_failed++; $display("FAIL dr_hold: got %h expected %h", ireq.addr, RPC + 64'h300); end
    iresp.data_ok = 1'b1;
    iresp.data    = instr_of(RPC + 64'h300);
    tick();
    iresp.data_ok = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL dr_drop: got %0b expected 0", out_valid); end
    wait_req(a, got);
    tests_run++;
    if (!got || a !== 64'h200) begin tests_failed++; $display("FAIL dr_target: got %h expected %h", a, 64'h200); end
    serve(a);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_instr !== instr_of(64'h200)) begin
      tests_failed++; $display("FAIL dr_out: got pc=%h instr=%h expected %h %h", out_pc, out_instr, 64'h200, instr_of(64'h200));
    end
    wait_req(a, got);
    tests_run++;
    if (!got || a !== 64'h204) begin tests_failed++; $display("FAIL dr_next: got %h expected %h", a, 64'h204); end
  endtask

  task automatic test_reset_mid_wait();
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tests_run++;
    if (ireq.valid !== 1'b0 || ireq.addr !== RPC || count !== 3'd0) begin
      tests_failed++; $display("FAIL rmw_reset: got valid=%0b addr=%h count=%0d expected 0 %h 0", ireq.valid, ireq.addr, count, RPC);
    end
    reset         = 1'b0;
    iresp.data_ok = 1'b1;
    iresp.data    = 32'hDEAD_BEEF;
    tick();
    iresp.data_ok = 1'b0;
    tests_run++;
    if (ireq.valid !== 1'b1 || ireq.addr !== RPC || out_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL rmw_stale: got valid=%0b addr=%h out_valid=%0b count=%0d expected 1 %h 0 0", ireq.valid, ireq.addr, out_valid, count, RPC);
    end
    serve(RPC);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== instr_of(RPC)) begin
      tests_failed++; $display("FAIL rmw_restart: got pc=%h instr=%h expected %h %h", out_pc, out_instr, RPC, instr_of(RPC));
    end
  endtask

  task automatic test_wrap_depth2();
    logic [63:0] exp;
    int n, max_cnt;
    exp     = RPC;
    n       = 0;
    max_cnt = 0;
    auto2   = 1'b1;
    reset2  = 1'b0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      tick();
      out_ready2 = (c % 3) != 2;
      if (int'(count2) > max_cnt) max_cnt = int'(count2);
      if (out_valid2 && out_ready2) begin
        tests_run++;
        if (out_pc2 !== exp || out_instr2 !== instr_of(exp)) begin
          tests_failed++; $display("FAIL wrap_out: got pc=%h instr=%h expected %h %h", out_pc2, out_instr2, exp, instr_of(exp));
        end
        exp = exp + 64'd4;
        n++;
      end
    end
    tests_run++;
    if (n !== 10) begin tests_failed++; $display("FAIL wrap_count: got %0d instructions expected 10", n); end
    tests_run++;
    if (max_cnt > 2) begin tests_failed++; $display("FAIL wrap_occupancy: got %0d expected at most 2", max_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    iresp          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    reset2         = 1'b1;
    out_ready2     = 1'b0;
    auto2          = 1'b0;
    tick();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_dataok_pop();
    test_double_redirect();
    test_reset_mid_wait();
    test_wrap_depth2();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
